// File: rtl/vdp_wb_host_bridge.sv
// Wishbone classic slave feeding the VDP register port: writes are posted through a FIFO,
// reads drain the FIFO first and then block. Define VDP_WB_READ_TIMEOUT_EN for a read timeout.
module vdp_wb_host_bridge #(
    parameter int ADDR_BITS  = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic                 host_write_en,
    output logic                 host_read_en,
    output logic [ADDR_BITS-1:0] host_address,
    output logic [15:0]          host_write_data,
    input  logic                 host_ready,
    input  logic [15:0]          host_read_data,
    input  logic                 host_read_data_valid,
    output logic [2:0]           o_dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = ADDR_BITS + 16;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACK      = 3'd1;
    localparam logic [2:0] S_RD_DRAIN = 3'd2;
    localparam logic [2:0] S_RD_REQ   = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_ACK   = 3'd5;

    logic [2:0]           r_state;
    logic [PW:0]          r_head;
    logic [PW:0]          r_tail;
    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] r_rd_addr;
    logic [31:0]          r_rd_word;

    logic                 w_req;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_wr_take;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tmo;
    logic [ADDR_BITS-1:0] w_adr;
    logic [15:0]          w_wdata;
    logic [EW-1:0]        w_head;
    logic                 w_unused;

    assign w_unused  = ^{wbs_sel_i[3:2], wbs_adr_i[31:ADDR_BITS+2], wbs_adr_i[1:0], wbs_dat_i[31:16]};
    assign w_adr     = wbs_adr_i[ADDR_BITS+1:2];
    assign w_wdata   = {wbs_sel_i[1] ? wbs_dat_i[15:8] : 8'h00, wbs_sel_i[0] ? wbs_dat_i[7:0] : 8'h00};
    assign w_req     = wbs_cyc_i & wbs_stb_i & (r_state == S_IDLE);
    assign w_empty   = (r_head == r_tail);
    assign w_full    = (r_head[PW] != r_tail[PW]) && (r_head[PW-1:0] == r_tail[PW-1:0]);
    assign w_wr_take = w_req & wbs_we_i & ~w_full;
    assign w_push    = w_wr_take & (wbs_sel_i[1:0] != 2'b00);
    assign w_head    = r_mem[r_head[PW-1:0]];

    // VDP handshake: a presented write/read transfers in any cycle where its enable and
    // host_ready are both high; the enable holds its payload stable until that cycle.
    assign host_write_en   = ~w_empty & (r_state != S_RD_REQ);
    assign host_read_en    = (r_state == S_RD_REQ);
    assign host_address    = host_read_en ? r_rd_addr : (w_empty ? '0 : w_head[EW-1:16]);
    assign host_write_data = w_empty ? 16'h0000 : w_head[15:0];
    assign w_pop           = host_write_en & host_ready;

    assign wbs_ack_o   = (r_state == S_ACK) || (r_state == S_RD_ACK);
    assign wbs_dat_o   = (r_state == S_RD_ACK) ? r_rd_word : 32'h0;
    assign o_dbg_state = r_state;

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_tail[PW-1:0]] <= {w_adr, w_wdata};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
        end
    end

`ifdef VDP_WB_READ_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;

    assign w_tmo = (r_tmo_cnt == 8'hFF);

    // Saturates so a request accepted on the last count still times out promptly.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_tmo_cnt <= 8'h00;
        end else if (r_state == S_RD_DRAIN) begin
            r_tmo_cnt <= 8'h00;
        end else if (((r_state == S_RD_REQ) || (r_state == S_RD_WAIT)) && !w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + 8'h01;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_rd_word <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_take) begin
                        r_state <= S_ACK;
                    end else if (w_req && !wbs_we_i) begin
                        r_state   <= S_RD_DRAIN;
                        r_rd_addr <= w_adr;
                    end
                end
                S_ACK:      r_state <= S_IDLE;
                S_RD_DRAIN: if (w_empty) r_state <= S_RD_REQ;
                S_RD_REQ: begin
                    if (host_ready) begin
                        r_state <= S_RD_WAIT;
                    end else if (w_tmo) begin
                        r_state   <= S_RD_ACK;
                        r_rd_word <= 32'hDEAD_0000;
                    end
                end
                S_RD_WAIT: begin
                    if (host_read_data_valid) begin
                        r_state   <= S_RD_ACK;
                        r_rd_word <= {16'h0000, host_read_data};
                    end else if (w_tmo) begin
                        r_state   <= S_RD_ACK;
                        r_rd_word <= 32'hDEAD_0000;
                    end
                end
                S_RD_ACK:   r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vdp_wb_host_bridge.sv
// Bench for vdp_wb_host_bridge: Wishbone master tasks, a VDP responder model, and queue-based
// scoreboards for Wishbone acks and VDP write transfers.
module tb_vdp_wb_host_bridge;
    localparam int AB = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, dat_i;
    logic          ack;
    logic [31:0]   dat_o;
    logic          wr_en, rd_en;
    logic [AB-1:0] h_addr;
    logic [15:0]   h_wdata;
    logic          h_ready;
    logic [15:0]   h_rdata;
    logic          h_rvalid;
    logic [2:0]    dbg_state;

    vdp_wb_host_bridge #(.ADDR_BITS(AB), .FIFO_DEPTH(4)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .host_write_en(wr_en), .host_read_en(rd_en), .host_address(h_addr),
        .host_write_data(h_wdata), .host_ready(h_ready), .host_read_data(h_rdata),
        .host_read_data_valid(h_rvalid), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [31:0]    exp_ack_q[$];
    logic [AB+15:0] exp_wr_q[$];
    logic [15:0]    ref_mem [64];   // register file as the host intends it (all posted writes, in order)
    logic [15:0]    vdp_mem [64];   // register file as the VDP actually received it
    int             n_checks = 0;
    int             n_pass = 0;
    int             ready_mode = 0; // 0 low, 1 high, 2 random
    bit             suppress_valid = 1'b0;
    int             rd_handshakes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- VDP responder + write monitor ----------------
    initial begin
        bit             rd_pending;
        int             rd_delay;
        logic [AB-1:0]  rd_addr_l;
        logic [AB+15:0] e_wr;
        rd_pending = 1'b0;
        rd_delay = 0;
        rd_addr_l = '0;
        h_ready = 1'b0;
        h_rvalid = 1'b0;
        h_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       h_ready = 1'b0;
                1:       h_ready = 1'b1;
                default: h_ready = 1'($urandom_range(0, 1));
            endcase
            h_rvalid = 1'b0;
            h_rdata  = 16'($urandom);
            if (rd_pending && !suppress_valid) begin
                if (rd_delay == 0) begin
                    h_rvalid   = 1'b1;
                    h_rdata    = vdp_mem[rd_addr_l];
                    rd_pending = 1'b0;
                end else begin
                    rd_delay--;
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                rd_pending = 1'b0;
            end else begin
                if (wr_en && rd_en) fail_now("wr_rd_exclusive");
                if (wr_en && h_ready) begin
                    if (exp_wr_q.size() == 0) begin
                        fail_now("unexpected_host_write");
                    end else begin
                        e_wr = exp_wr_q.pop_front();
                        check("host_write", 32'({h_addr, h_wdata}), 32'(e_wr));
                    end
                    vdp_mem[h_addr] = h_wdata;
                end
                if (rd_en && h_ready) begin
                    check("drained_before_read", 32'(exp_wr_q.size()), 32'd0);
                    rd_pending = 1'b1;
                    rd_delay   = $urandom_range(0, 3);
                    rd_addr_l  = h_addr;
                    rd_handshakes++;
                end
            end
        end
    end

    // ---------------- Wishbone ack monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ack) begin
                if (exp_ack_q.size() == 0) fail_now("unexpected_ack");
                else check("wb_ack_data", dat_o, exp_ack_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
    endtask

    task automatic wb_drive(input bit w, input logic [AB-1:0] a, input logic [15:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = $urandom;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s;
        adr   = {r[31:8], a, r[1:0]};
        dat_i = {r[15:0], d};
    endtask

    task automatic wait_ack(input string name, input int budget, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (ack) break;
            lat++;
            if (lat >= budget) begin
                fail_now(name);
                break;
            end
        end
        @(posedge clk); #1;
        wb_idle();
    endtask

    task automatic wb_write(input logic [AB-1:0] a, input logic [15:0] d, input logic [3:0] s);
        logic [15:0] m;
        int lat;
        m = {s[1] ? d[15:8] : 8'h00, s[0] ? d[7:0] : 8'h00};
        if (s[1:0] != 2'b00) begin
            exp_wr_q.push_back({a, m});
            ref_mem[a] = m;
        end
        exp_ack_q.push_back(32'h0);
        wb_drive(1'b1, a, d, s);
        wait_ack("write_ack_timeout", 400, lat);
    endtask

    task automatic wb_read(input logic [AB-1:0] a);
        int lat;
        exp_ack_q.push_back({16'h0, ref_mem[a]});
        wb_drive(1'b0, a, 16'h0, 4'hF);
        wait_ack("read_ack_timeout", 400, lat);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        fail_now("watchdog");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int lat;
        int cnt;
        int hs0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'h0;
            vdp_mem[i] = 16'h0;
        end
        wb_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat_o", dat_o, 32'd0);
        check("rst_write_en", 32'(wr_en), 32'd0);
        check("rst_read_en", 32'(rd_en), 32'd0);
        check("rst_address", 32'(h_addr), 32'd0);
        check("rst_write_data", 32'(h_wdata), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 1;
        cycles(2);

        // Single write timing: 0x1234 to byte address 0x08
        exp_wr_q.push_back({6'd2, 16'h1234});
        ref_mem[2] = 16'h1234;
        exp_ack_q.push_back(32'h0);
        wb_drive(1'b1, 6'd2, 16'h1234, 4'hF);
        adr = 32'h0000_0008;
        @(negedge clk);
        check("w1_no_ack_cycle_n", 32'(ack), 32'd0);
        @(negedge clk);
        check("w1_ack_n1", 32'(ack), 32'd1);
        check("w1_write_en_n1", 32'(wr_en), 32'd1);
        check("w1_address", 32'(h_addr), 32'd2);
        check("w1_write_data", 32'(h_wdata), 32'h1234);
        @(posedge clk); #1;
        wb_idle();
        @(negedge clk);
        check("w1_fifo_empty_n2", 32'(wr_en), 32'd0);

        // FIFO full stall with host_ready low
        ready_mode = 0;
        cycles(2);
        for (int i = 0; i < 4; i++) wb_write(6'(10 + i), 16'($urandom), 4'hF);
        exp_wr_q.push_back({6'd14, 16'hC0DE});
        ref_mem[14] = 16'hC0DE;
        exp_ack_q.push_back(32'h0);
        wb_drive(1'b1, 6'd14, 16'hC0DE, 4'hF);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack) cnt++;
        end
        check("stall_no_ack", 32'(cnt), 32'd0);
        check("stall_fifo_holding", 32'(wr_en), 32'd1);
        @(posedge clk); #2;
        ready_mode = 1;
        wait_ack("stall_release_ack", 50, lat);
        cycles(8);
        check("stall_all_drained", 32'(exp_wr_q.size()), 32'd0);

        // Read-after-write ordering
        ready_mode = 0;
        cycles(2);
        wb_write(6'd1, 16'hBEEF, 4'hF);
        fork
            wb_read(6'd1);
            begin
                cycles(3);
                ready_mode = 1;
            end
        join
        check("raw_vdp_value", 32'(vdp_mem[1]), 32'h0000BEEF);

        // Write with no low byte selects: acked, nothing pushed
        ready_mode = 0;
        cycles(2);
        wb_write(6'd3, 16'h5555, 4'b1100);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (wr_en) cnt++;
        end
        check("sel_none_no_push", 32'(cnt), 32'd0);

        // Reset with two posted writes still queued
        wb_write(6'd20, 16'h2020, 4'hF);
        wb_write(6'd21, 16'h2121, 4'hF);
        check("rst_q_pending_before", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        exp_wr_q.delete();
        exp_ack_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_mem = vdp_mem;
        @(negedge clk);
        check("rst_q_write_en", 32'(wr_en), 32'd0);
        ready_mode = 1;
        cycles(4);

        // Reset while waiting for read data
        suppress_valid = 1'b1;
        hs0 = rd_handshakes;
        wb_drive(1'b0, 6'd5, 16'h0, 4'hF);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) cnt++;
        end
        check("rdwait_no_ack", 32'(cnt), 32'd0);
        check("rdwait_handshake", 32'(rd_handshakes - hs0), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        wb_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        suppress_valid = 1'b0;
        @(negedge clk);
        check("rdrst_ack", 32'(ack), 32'd0);
        check("rdrst_dat_o", dat_o, 32'd0);
        check("rdrst_write_en", 32'(wr_en), 32'd0);
        check("rdrst_read_en", 32'(rd_en), 32'd0);
        check("rdrst_address", 32'(h_addr), 32'd0);
        check("rdrst_write_data", 32'(h_wdata), 32'd0);
        cycles(4);

`ifdef VDP_WB_READ_TIMEOUT_EN
        // Read timeout when the VDP never returns data
        suppress_valid = 1'b1;
        exp_ack_q.push_back(32'hDEAD_0000);
        wb_drive(1'b0, 6'd7, 16'h0, 4'hF);
        wait_ack("timeout_ack_missing", 400, lat);
        check("timeout_latency", 32'(lat), 32'd258);
        suppress_valid = 1'b0;
        cycles(8);
`endif

        // Randomized mix of writes and reads
        for (int i = 0; i < 80; i++) begin
            if ((i % 10) == 0) ready_mode = $urandom_range(1, 2);
            if ($urandom_range(0, 9) < 6) wb_write(6'($urandom_range(0, 15)), 16'($urandom), 4'($urandom_range(0, 15)));
            else wb_read(6'($urandom_range(0, 15)));
            cycles($urandom_range(0, 2));
        end

        ready_mode = 1;
        cnt = 0;
        while ((exp_wr_q.size() != 0 || exp_ack_q.size() != 0) && cnt < 500) begin
            cycles(1);
            cnt++;
        end
        cycles(4);
        check("end_wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        check("end_ack_queue_empty", 32'(exp_ack_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
